core_int_ctrl: RTL and testbench
================================

Name: core_int_ctrl

Overview:
Inter-core interrupt (IPI) controller shared by all cores of the multi-core top level.
- Decodes each core's special-register bus writes to SREG_MT_IRQ addresses 0x9–0xB.
- Keeps per-core pending-sender sets, per-core outgoing message words and a round-robin source pointer per receiving core.
- Drives each core's i_core_int level and i_core_int_sreg readback value.

Parameters:
CORES, 2, number of cores; 1..8.
RW, 16, special-register bus width.

Ports:
i_clk  in  1  clock.
i_rst  in  1  reset; synchronous, active-high.
i_sr_addr  in  CORES*RW  per-core sr_bus_addr; core k occupies slice [k*RW +: RW].
i_sr_data  in  CORES*RW  per-core sr_bus_data_o.
i_sr_we  in  CORES  per-core sr_bus_we; only meaningful in the execute-commit cycle.
o_core_int  out  CORES  level interrupt request to core k.
o_core_int_sreg  out  CORES*RW  combinational readback for core k, selected by its own i_sr_addr.

Behaviour:
State, all reset to 0 unless noted:
- pend[k][j]: core j has signalled core k.
- msg[j]: RW bits, outgoing message of core j.
- ptr[k]: clog2(CORES) bits.
- mask[k]: CORES bits, reset all-ones.

Current source src[k]:
- First j with (pend[k][j] & mask[k][j]), searched round-robin starting at ptr[k] and wrapping at CORES.
- src_v[k] = 1 when any such j exists.

Register map, per writing/reading core j:
- 0x9 write (SEND): for every target t with data[t]=1 (t<CORES), set pend[t][j]. Bits >= CORES are ignored. Mask 0 is a no-op. Self-send is allowed.
- 0x9 read: {0, pend[j]} zero-extended.
- 0xA write (CLEAR): pend[j][i] cleared for every data[i]=1. If src_v[j], ptr[j] <= (src[j]+1) mod CORES.
- 0xA read: {src_v[j], 0…, src[j]} (bit 15 = valid).
- 0xB write: msg[j] <= data.
- 0xB read: msg[src[j]] if src_v[j], else 0.
- Any other address: read returns 0, write is ignored.

Update rules:
- All cores' writes are applied in the same clock edge, with no serialisation.
- Simultaneous SENDs from several cores to one target OR together.
- SEND and CLEAR of the same pend bit in one cycle: set wins, so an event is never lost.
- A 0xB write and a read of that msg in the same cycle: the read returns the old value.

Interrupt output:
- o_core_int[k] = |(pend[k] & mask[k]), decoded from registers.
- Latency: a SEND commit in cycle t asserts the target's o_core_int from cycle t+1.
- Deassertion follows the CLEAR edge.
- Level semantics: the core masks the request itself through irq_en.

Readback:
- Purely combinational from registers, with no added latency.
- Valid in the same cycle as the core's i_imm decode.

Reset mid-operation: all state returns to reset values at the next edge; pending events are discarded.

Optional Feature:
CORE_INT_MASK_EN
- Defined: a 0x9 write with data[15]=1 loads mask[j] <= data[CORES-1:0] instead of sending.
  - Masked senders still latch into pend.
  - Masked senders are excluded from o_core_int and from src selection.
  - A 0x9 read returns {mask[j] in bits [15:8], pend[j] in bits [7:0]}; CORES<=8 guarantees fit.
- Undefined:
  - mask is constant all-ones and has no storage.
  - data[15] is ignored, so a 0x9 write with data[15]=1 is an ordinary SEND.
  - A 0x9 read returns pend only.

Test Plan:
- CORES=2, reset, core0 writes 0x9=0x0002 at cycle t -> o_core_int=2'b10 at t+1; core1 reads 0x9 = 0x0001, 0xA = 0x8000.
- Core0 writes 0xB=0xBEEF, then 0x9=0x0002; core1 reads 0xB -> 0xBEEF; core1 writes 0xA=0x0001 -> o_core_int[1]=0 next cycle, ptr[1]=1.
- Core0 and core1 both SEND to core1 in the same cycle -> pend[1]=2'b11.
  - src[1]=0 after reset.
  - After CLEAR of 0x0001: src[1]=1, 0xA read = 0x8001, o_core_int[1] stays 1.
- Same cycle: core0 SEND to core1 and core1 CLEAR 0x0001 -> pend[1][0]=1 and o_core_int[1]=1 (set wins).
- Any pend set, assert i_rst one cycle -> o_core_int=0, all readbacks 0, masks all-ones.
- With CORE_INT_MASK_EN:
  - Core1 writes 0x9=0x8000 (mask 0); core0 SENDs to core1 -> o_core_int[1]=0, 0x9 read = 0x0001.
  - Core1 writes 0x9=0x8003 -> o_core_int[1]=1 next cycle.

Source files
------------

// File: rtl/core_int_ctrl.sv
// core_int_ctrl: inter-core interrupt controller with per-core pending-sender sets,
// message words and round-robin source selection. Optional feature macro: CORE_INT_MASK_EN.
module core_int_ctrl #(
    parameter int CORES = 2,
    parameter int RW    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [CORES*RW-1:0]   i_sr_addr,
    input  logic [CORES*RW-1:0]   i_sr_data,
    input  logic [CORES-1:0]      i_sr_we,
    output logic [CORES-1:0]      o_core_int,
    output logic [CORES*RW-1:0]   o_core_int_sreg
);
    localparam int PW = (CORES > 1) ? $clog2(CORES) : 1;
    localparam logic [RW-1:0] A_SEND = RW'(9);
    localparam logic [RW-1:0] A_CLR  = RW'(10);
    localparam logic [RW-1:0] A_MSG  = RW'(11);

    logic [CORES-1:0] r_pend [CORES];
    logic [RW-1:0]    r_msg  [CORES];
    logic [PW-1:0]    r_ptr  [CORES];
    logic [CORES-1:0] w_mask [CORES];

    logic [CORES-1:0] w_we_send;
    logic [CORES-1:0] w_we_clr;
    logic [CORES-1:0] w_we_msg;
    logic [CORES-1:0] w_set      [CORES];
    logic [CORES-1:0] w_clr      [CORES];
    logic [PW-1:0]    w_src      [CORES];
    logic [PW-1:0]    w_ptr_next [CORES];
    logic [CORES-1:0] w_src_v;

`ifdef CORE_INT_MASK_EN
    logic [CORES-1:0] r_mask [CORES];
    logic [CORES-1:0] w_we_mask;

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < CORES; k++) begin
            if (i_rst)
                r_mask[k] <= '1;
            else if (w_we_mask[k])
                r_mask[k] <= i_sr_data[k*RW +: CORES];
        end
    end

    always_comb begin
        for (int k = 0; k < CORES; k++)
            w_mask[k] = r_mask[k];
    end
`else
    always_comb begin
        for (int k = 0; k < CORES; k++)
            w_mask[k] = '1;
    end
`endif

    always_comb begin
        logic [CORES-1:0]   w_hit;
        logic [2*CORES-1:0] w_dbl;
        logic [PW:0]        w_sum;
        w_hit = '0;
        w_dbl = '0;
        w_sum = '0;
        for (int k = 0; k < CORES; k++) begin
`ifdef CORE_INT_MASK_EN
            // data[RW-1] turns a 0x9 write into a mask load instead of a send
            w_we_mask[k] = i_sr_we[k] && (i_sr_addr[k*RW +: RW] == A_SEND) && i_sr_data[k*RW + RW - 1];
            w_we_send[k] = i_sr_we[k] && (i_sr_addr[k*RW +: RW] == A_SEND) && !i_sr_data[k*RW + RW - 1];
`else
            w_we_send[k] = i_sr_we[k] && (i_sr_addr[k*RW +: RW] == A_SEND);
`endif
            w_we_clr[k] = i_sr_we[k] && (i_sr_addr[k*RW +: RW] == A_CLR);
            w_we_msg[k] = i_sr_we[k] && (i_sr_addr[k*RW +: RW] == A_MSG);
            w_clr[k]    = w_we_clr[k] ? i_sr_data[k*RW +: CORES] : '0;
        end
        for (int t = 0; t < CORES; t++) begin
            w_set[t] = '0;
            for (int j = 0; j < CORES; j++)
                w_set[t][j] = w_we_send[j] && i_sr_data[j*RW + t];
        end
        // Rotate the eligible set so the search starts at ptr; lowest offset wins.
        for (int k = 0; k < CORES; k++) begin
            w_hit      = r_pend[k] & w_mask[k];
            w_dbl      = {w_hit, w_hit} >> r_ptr[k];
            w_src_v[k] = 1'b0;
            w_src[k]   = '0;
            for (int off = CORES - 1; off >= 0; off--) begin
                if (w_dbl[off]) begin
                    w_src_v[k] = 1'b1;
                    w_sum      = {1'b0, r_ptr[k]} + (PW+1)'(off);
                    w_src[k]   = (w_sum >= (PW+1)'(CORES)) ? PW'(w_sum - (PW+1)'(CORES)) : PW'(w_sum);
                end
            end
            w_ptr_next[k] = (w_src[k] == PW'(CORES - 1)) ? '0 : w_src[k] + 1'b1;
        end
    end

    // Set terms are OR-ed after the clear so a coincident send is never lost.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < CORES; k++) begin
            if (i_rst) begin
                r_pend[k] <= '0;
                r_msg[k]  <= '0;
                r_ptr[k]  <= '0;
            end else begin
                r_pend[k] <= (r_pend[k] & ~w_clr[k]) | w_set[k];
                if (w_we_clr[k] && w_src_v[k])
                    r_ptr[k] <= w_ptr_next[k];
                if (w_we_msg[k])
                    r_msg[k] <= i_sr_data[k*RW +: RW];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CORES; gi++) begin : g_core
            logic [RW-1:0] w_addr;
            logic [RW-1:0] w_rd;

            assign w_addr = i_sr_addr[gi*RW +: RW];

            always_comb begin
                w_rd = '0;
                case (w_addr)
                    A_SEND: begin
                        w_rd[CORES-1:0] = r_pend[gi];
`ifdef CORE_INT_MASK_EN
                        w_rd[8 +: CORES] = r_mask[gi];
`endif
                    end
                    A_CLR: begin
                        w_rd[RW-1]   = w_src_v[gi];
                        w_rd[PW-1:0] = w_src[gi];
                    end
                    A_MSG: begin
                        if (w_src_v[gi])
                            w_rd = r_msg[w_src[gi]];
                    end
                    default: ;
                endcase
            end

            assign o_core_int_sreg[gi*RW +: RW] = w_rd;
            assign o_core_int[gi]               = |(r_pend[gi] & w_mask[gi]);
        end
    endgenerate
endmodule

// File: tb/tb_core_int_ctrl.sv
// Self-checking bench for core_int_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a set-based behavioural model.
`timescale 1ns/1ps
module tb_core_int_ctrl;
    localparam int CORES = 2;
    localparam int RW    = 16;
`ifdef CORE_INT_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [CORES*RW-1:0] addr;
    logic [CORES*RW-1:0] data;
    logic [CORES-1:0]    we;
    logic [CORES-1:0]    irq;
    logic [CORES*RW-1:0] sreg;

    int n_total = 0;
    int n_bad   = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    core_int_ctrl #(.CORES(CORES), .RW(RW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sr_addr      (addr),
        .i_sr_data      (data),
        .i_sr_we        (we),
        .o_core_int     (irq),
        .o_core_int_sreg(sreg)
    );

    // Model: pending sets as bit arrays, pointer as a plain integer.
    bit [CORES-1:0] m_pend [CORES];
    bit [CORES-1:0] m_mask [CORES];
    logic [15:0]    m_msg  [CORES];
    int             m_ptr  [CORES];

    function automatic int m_src(int k);
        for (int off = 0; off < CORES; off++) begin
            int j;
            j = (m_ptr[k] + off) % CORES;
            if (m_pend[k][j] && m_mask[k][j])
                return j;
        end
        return -1;
    endfunction

    function automatic logic [15:0] exp_rd(int k, logic [15:0] a);
        int s;
        s = m_src(k);
        case (a)
            16'h9:   return 16'(m_pend[k]) | (MASK_EN ? (16'(m_mask[k]) << 8) : 16'h0);
            16'hA:   return (s < 0) ? 16'h0 : (16'h8000 | 16'(s));
            16'hB:   return (s < 0) ? 16'h0 : m_msg[s];
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic [CORES-1:0] exp_irq();
        logic [CORES-1:0] r;
        for (int k = 0; k < CORES; k++)
            r[k] = |(m_pend[k] & m_mask[k]);
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit [CORES-1:0] np [CORES];
        bit [CORES-1:0] nm [CORES];
        logic [15:0]    nmsg [CORES];
        int             nptr [CORES];
        if (rst) begin
            for (int k = 0; k < CORES; k++) begin
                m_pend[k] = '0;
                m_mask[k] = '1;
                m_msg[k]  = '0;
                m_ptr[k]  = 0;
            end
            return;
        end
        np = m_pend; nm = m_mask; nmsg = m_msg; nptr = m_ptr;
        for (int j = 0; j < CORES; j++) begin
            logic [15:0] a, d;
            int s;
            a = addr[j*RW +: RW];
            d = data[j*RW +: RW];
            if (!we[j]) continue;
            if (a == 16'hA) begin
                s = m_src(j);
                for (int i = 0; i < CORES; i++)
                    if (d[i]) np[j][i] = 1'b0;
                if (s >= 0) nptr[j] = (s + 1) % CORES;
            end
            if (a == 16'hB) nmsg[j] = d;
            if (a == 16'h9 && MASK_EN && d[15]) nm[j] = d[CORES-1:0];
        end
        for (int j = 0; j < CORES; j++) begin
            logic [15:0] a, d;
            a = addr[j*RW +: RW];
            d = data[j*RW +: RW];
            if (we[j] && a == 16'h9 && !(MASK_EN && d[15]))
                for (int t = 0; t < CORES; t++)
                    if (d[t]) np[t][j] = 1'b1;
        end
        m_pend = np; m_mask = nm; m_msg = nmsg; m_ptr = nptr;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set(int c, logic [15:0] a, logic [15:0] d, bit w);
        addr[c*RW +: RW] = a;
        data[c*RW +: RW] = d;
        we[c]            = w;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("irq", 32'(irq), 32'(exp_irq()));
            for (int k = 0; k < CORES; k++)
                chk($sformatf("sreg%0d addr=%h", k, addr[k*RW +: RW]),
                    32'(sreg[k*RW +: RW]), 32'(exp_rd(k, addr[k*RW +: RW])));
        end
    end

    initial begin
        logic [15:0] rb0;
        rst = 1'b1; we = '0; addr = '0; data = '0;
        step();
        cmp_en = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("reset_irq", 32'(irq), 32'h0);

        // Core0 sends to core1.
        set(0, 16'h9, 16'h0002, 1'b1); set(1, 16'h9, 16'h0, 1'b0);
        step();
        set(0, 16'h0, 16'h0, 1'b0);
        #1 chk("send_irq", 32'(irq), 32'h2);
        chk("send_r9", 32'(sreg[31:16]), 32'h0001);
        set(1, 16'hA, 16'h0, 1'b0);
        #1 chk("send_rA", 32'(sreg[31:16]), 32'h8000);

        // Message then clear; pointer advances to 1.
        set(0, 16'hB, 16'hBEEF, 1'b1);
        step();
        set(0, 16'h9, 16'h0002, 1'b1);
        step();
        set(0, 16'h0, 16'h0, 1'b0); set(1, 16'hB, 16'h0, 1'b0);
        #1 chk("msg_rB", 32'(sreg[31:16]), 32'hBEEF);
        set(1, 16'hA, 16'h0001, 1'b1);
        step();
        set(1, 16'h0, 16'h0, 1'b0);
        #1 chk("clr_irq1", 32'(irq[1]), 32'h0);
        set(0, 16'h9, 16'h0002, 1'b1); set(1, 16'h9, 16'h0002, 1'b1);
        step();
        set(0, 16'h0, 16'h0, 1'b0); set(1, 16'hA, 16'h0, 1'b0);
        #1 chk("ptr_rA", 32'(sreg[31:16]), 32'h8001);

        // Simultaneous sends after reset, then round-robin clear.
        rst = 1'b1; we = '0;
        step();
        rst = 1'b0;
        set(0, 16'h9, 16'h0002, 1'b1); set(1, 16'h9, 16'h0002, 1'b1);
        step();
        set(0, 16'h0, 16'h0, 1'b0); set(1, 16'h9, 16'h0, 1'b0);
        #1 chk("both_r9", 32'(sreg[31:16]), 32'h0003);
        set(1, 16'hA, 16'h0, 1'b0);
        #1 chk("both_rA", 32'(sreg[31:16]), 32'h8000);
        set(1, 16'hA, 16'h0001, 1'b1);
        step();
        set(1, 16'hA, 16'h0, 1'b0);
        #1 chk("rr_rA", 32'(sreg[31:16]), 32'h8001);
        chk("rr_irq1", 32'(irq[1]), 32'h1);

        // Same-cycle send and clear of one bit: set wins.
        set(0, 16'h9, 16'h0002, 1'b1); set(1, 16'hA, 16'h0001, 1'b1);
        step();
        set(0, 16'h0, 16'h0, 1'b0); set(1, 16'h9, 16'h0, 1'b0);
        #1 chk("setwins_r9", 32'(sreg[31:16]), 32'h0003);
        chk("setwins_irq1", 32'(irq[1]), 32'h1);

        // Reset with pending state.
        rst = 1'b1;
        step();
        rst = 1'b0;
        rb0 = MASK_EN ? 16'h0300 : 16'h0000;
        set(0, 16'h9, 16'h0, 1'b0); set(1, 16'h9, 16'h0, 1'b0);
        #1 chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_r9_c0", 32'(sreg[15:0]), 32'(rb0));
        chk("rst_r9_c1", 32'(sreg[31:16]), 32'(rb0));
        set(0, 16'hA, 16'h0, 1'b0); set(1, 16'hB, 16'h0, 1'b0);
        #1 chk("rst_rA_c0", 32'(sreg[15:0]), 32'h0);
        chk("rst_rB_c1", 32'(sreg[31:16]), 32'h0);

`ifdef CORE_INT_MASK_EN
        set(0, 16'h0, 16'h0, 1'b0); set(1, 16'h9, 16'h8000, 1'b1);
        step();
        set(0, 16'h9, 16'h0002, 1'b1); set(1, 16'h9, 16'h0, 1'b0);
        step();
        set(0, 16'h0, 16'h0, 1'b0);
        #1 chk("mask_irq1", 32'(irq[1]), 32'h0);
        chk("mask_r9", 32'(sreg[31:16]), 32'h0001);
        set(1, 16'h9, 16'h8003, 1'b1);
        step();
        set(1, 16'h9, 16'h0, 1'b0);
        #1 chk("unmask_irq1", 32'(irq[1]), 32'h1);
`endif

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < CORES; c++) begin
                logic [15:0] a;
                case ($urandom_range(0, 4))
                    0, 1:    a = 16'h9;
                    2:       a = 16'hA;
                    3:       a = 16'hB;
                    default: a = 16'($urandom_range(0, 15));
                endcase
                set(c, a, 16'($urandom), 1'($urandom_range(0, 1)));
            end
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0; we = '0;
        step();
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
